// File: rtl/isa_pkg.sv
// Shared ISA definitions for the execute path.
// Contents:
//   - Load/store opcode constants as decoded by the 12-bit address ALU
//     (LWI/SWI immediate forms, the TYPE_LS major opcode, LW/SW sub-opcodes).
//   - dm_access FSM state encoding.
//   - Default data-word width.
package isa_pkg;

  localparam int DATA_W_DEF = 32;

  // Major opcodes of the load/store group (4-bit opcode field).
  localparam logic [3:0] OP_LWI     = 4'b1000;
  localparam logic [3:0] OP_SWI     = 4'b1001;
  localparam logic [3:0] OP_TYPE_LS = 4'b1010;

  // Sub-opcodes under OP_TYPE_LS.
  localparam logic [1:0] SUB_LW = 2'b00;
  localparam logic [1:0] SUB_SW = 2'b01;

  // dm_access controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } dm_state_e;

endpackage

// File: rtl/dm_access.sv
// dm_access: load/store responder between the address ALU and a single
// synchronous data-memory port.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   ls_valid/ls_ready   request handshake (accepted only while ls_ready=1)
//   ls_is_store         1 = SW/SWI, 0 = LW/LWI
//   ls_addr, ls_wdata   byte address and store data
//   ls_done, ls_err     one-cycle completion pulse, error qualifier
//   ls_rdata            data of the last completed load
//   dm_enable/dm_write  one-cycle memory strobe and write qualifier
//   dm_addr, dm_wdata   word address and store data to memory
//   dm_rdata            memory read data, valid RD_LAT cycles after dm_enable
// Every output except ls_ready is registered; ls_ready is decoded from state.
module dm_access
  import isa_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = 1,
  parameter int DM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ls_valid,
  input  logic              ls_is_store,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic              ls_done,
  output logic              ls_err,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              dm_enable,
  output logic              dm_write,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int              CNT_W     = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);
  localparam logic [31:0]     WORDS_LIM = 32'(DM_WORDS);

  dm_state_e         state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ls_done_q, ls_done_d;
  logic              ls_err_q, ls_err_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              dm_enable_q, dm_enable_d;
  logic              dm_write_q, dm_write_d;
  logic [ADDR_W-3:0] dm_addr_q, dm_addr_d;
  logic [DATA_W-1:0] dm_wdata_q, dm_wdata_d;

  logic [31:0] word_idx_s;
  logic        req_bad_s;

  // Word index widened so the range check works even when DM_WORDS exceeds
  // the address space (then no address is ever out of range).
  assign word_idx_s = 32'(ls_addr[ADDR_W-1:2]);
  assign req_bad_s  = (ls_addr[1:0] != 2'b00) || (word_idx_s >= WORDS_LIM);

  // Reset must block acceptance in the same cycle it is asserted.
  assign ls_ready = (state_q == ST_IDLE) && !reset;

  assign ls_done   = ls_done_q;
  assign ls_err    = ls_err_q;
  assign ls_rdata  = ls_rdata_q;
  assign dm_enable = dm_enable_q;
  assign dm_write  = dm_write_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;

  // Next-state logic; output _d values are what the outputs show next cycle,
  // so strobes are raised on the transition into the state that owns them.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    cnt_d       = cnt_q;
    ls_done_d   = 1'b0;
    ls_err_d    = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    dm_enable_d = 1'b0;
    dm_write_d  = 1'b0;
    dm_addr_d   = dm_addr_q;
    dm_wdata_d  = dm_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ls_valid) begin
          is_store_d = ls_is_store;
          if (req_bad_s) begin
            state_d   = ST_ERR;
            ls_done_d = 1'b1;
            ls_err_d  = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            dm_enable_d = 1'b1;
            dm_write_d  = ls_is_store;
            dm_addr_d   = ls_addr[ADDR_W-1:2];
            dm_wdata_d  = ls_wdata;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (is_store_q) begin
          state_d   = ST_DONE;
          ls_done_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        // Counter reaches zero in the cycle the memory presents read data.
        if (cnt_q == '0) begin
          state_d    = ST_DONE;
          ls_done_d  = 1'b1;
          ls_rdata_d = dm_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any request in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      is_store_q  <= 1'b0;
      cnt_q       <= '0;
      ls_done_q   <= 1'b0;
      ls_err_q    <= 1'b0;
      ls_rdata_q  <= '0;
      dm_enable_q <= 1'b0;
      dm_write_q  <= 1'b0;
      dm_addr_q   <= '0;
      dm_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      cnt_q       <= cnt_d;
      ls_done_q   <= ls_done_d;
      ls_err_q    <= ls_err_d;
      ls_rdata_q  <= ls_rdata_d;
      dm_enable_q <= dm_enable_d;
      dm_write_q  <= dm_write_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
    end
  end

endmodule

// File: tb/tb_dm_access.sv
// Bench for dm_access. Two instances with independent stimulus:
//   inst 0: RD_LAT=1, DM_WORDS=256   inst 1: RD_LAT=3, DM_WORDS=1024
// Each drives a dm_sram_model. Expected results come from a word-array
// reference memory plus the latency/error rules of the block.

// Synchronous SRAM model: write at the enable edge, read data RD_LAT cycles
// after the enable cycle. clr zero-fills contents.
module dm_sram_model #(
  parameter int AW       = 10,
  parameter int DW       = 32,
  parameter int RD_LAT   = 1,
  parameter int DM_WORDS = 1024
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem  [DM_WORDS];
  logic [DW-1:0] pipe [RD_LAT];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      if (en && we && (int'(addr) < DM_WORDS)) mem[addr] <= wdata;
      for (int i = RD_LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      pipe[0] <= (en && !we && (int'(addr) < DM_WORDS)) ? mem[addr] : '0;
    end
  end

  assign rdata = pipe[RD_LAT-1];
endmodule

module tb_dm_access;
  localparam int LAT0 = 1, WORDS0 = 256;
  localparam int LAT1 = 3, WORDS1 = 1024;

  logic        clk = 1'b0;
  logic        mclr;
  logic        reset       [2];
  logic        ls_valid    [2];
  logic        ls_is_store [2];
  logic [11:0] ls_addr     [2];
  logic [31:0] ls_wdata    [2];
  logic        ls_ready    [2];
  logic        ls_done     [2];
  logic        ls_err      [2];
  logic [31:0] ls_rdata    [2];
  logic        dm_enable   [2];
  logic        dm_write    [2];
  logic [9:0]  dm_addr     [2];
  logic [31:0] dm_wdata    [2];
  logic [31:0] dm_rdata    [2];

  int checks;
  int errors;
  logic [31:0] ref_mem [2][1024];
  logic [31:0] rd_ref  [2];

  always #5 clk = ~clk;

  dm_access #(.ADDR_W(12), .DATA_W(32), .RD_LAT(LAT0), .DM_WORDS(WORDS0)) u_dut0 (
    .clk(clk), .reset(reset[0]), .ls_valid(ls_valid[0]), .ls_is_store(ls_is_store[0]),
    .ls_addr(ls_addr[0]), .ls_wdata(ls_wdata[0]), .ls_ready(ls_ready[0]), .ls_done(ls_done[0]),
    .ls_err(ls_err[0]), .ls_rdata(ls_rdata[0]), .dm_enable(dm_enable[0]), .dm_write(dm_write[0]),
    .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]), .dm_rdata(dm_rdata[0]));

  dm_access #(.ADDR_W(12), .DATA_W(32), .RD_LAT(LAT1), .DM_WORDS(WORDS1)) u_dut1 (
    .clk(clk), .reset(reset[1]), .ls_valid(ls_valid[1]), .ls_is_store(ls_is_store[1]),
    .ls_addr(ls_addr[1]), .ls_wdata(ls_wdata[1]), .ls_ready(ls_ready[1]), .ls_done(ls_done[1]),
    .ls_err(ls_err[1]), .ls_rdata(ls_rdata[1]), .dm_enable(dm_enable[1]), .dm_write(dm_write[1]),
    .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]), .dm_rdata(dm_rdata[1]));

  dm_sram_model #(.AW(10), .DW(32), .RD_LAT(LAT0), .DM_WORDS(WORDS0)) u_mem0 (
    .clk(clk), .clr(mclr), .en(dm_enable[0]), .we(dm_write[0]), .addr(dm_addr[0]),
    .wdata(dm_wdata[0]), .rdata(dm_rdata[0]));

  dm_sram_model #(.AW(10), .DW(32), .RD_LAT(LAT1), .DM_WORDS(WORDS1)) u_mem1 (
    .clk(clk), .clr(mclr), .en(dm_enable[1]), .we(dm_write[1]), .addr(dm_addr[1]),
    .wdata(dm_wdata[1]), .rdata(dm_rdata[1]));

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int words_of(input int k);
    return (k == 0) ? WORDS0 : WORDS1;
  endfunction

  // One request through instance k, checked cycle by cycle against the rules.
  // poke drives stray ls_valid pulses while the request is still busy.
  task automatic do_req(input int k, input bit st, input logic [11:0] a,
                        input logic [31:0] wd, input bit poke);
    bit bad;
    int lat, en_n, en_at, done_n, done_at, waitc, exp_done;
    logic [31:0] exp_rd, cur_wd;
    lat = lat_of(k);
    bad = (a[1:0] != 2'b00) || (int'(a[11:2]) >= words_of(k));
    waitc = 0;
    while (ls_ready[k] !== 1'b1 && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    checks++;
    if (ls_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout inst%0d ls_ready=%b want 1", k, ls_ready[k]);
    end
    cur_wd = dm_wdata[k];
    ls_valid[k] = 1'b1; ls_is_store[k] = st; ls_addr[k] = a; ls_wdata[k] = wd;
    @(negedge clk);
    ls_valid[k] = 1'b0;
    exp_rd = rd_ref[k];
    if (!bad && !st) exp_rd = ref_mem[k][a[11:2]];
    en_n = 0; en_at = 0; done_n = 0; done_at = 0;
    for (int i = 1; i <= 8; i++) begin
      if (done_n == 0) begin
        checks++;
        if (ls_ready[k] !== 1'b0) begin
          errors++;
          $display("FAIL ready_busy inst%0d cyc T+%0d ls_ready=%b want 0", k, i, ls_ready[k]);
        end
      end
      checks++;
      if (dm_enable[k] === 1'b1) begin
        en_n++; en_at = i;
        if (dm_write[k] !== st || dm_addr[k] !== a[11:2] || dm_wdata[k] !== wd) begin
          errors++;
          $display("FAIL access inst%0d got we=%b addr=%h wd=%h want we=%b addr=%h wd=%h",
                   k, dm_write[k], dm_addr[k], dm_wdata[k], st, a[11:2], wd);
        end
        cur_wd = wd;
      end else if (dm_write[k] !== 1'b0 || dm_wdata[k] !== cur_wd) begin
        errors++;
        $display("FAIL idle_bus inst%0d got we=%b wd=%h want we=0 wd=%h", k, dm_write[k], dm_wdata[k], cur_wd);
      end
      if (ls_done[k] === 1'b1) begin
        done_n++; done_at = i;
        checks++;
        if (ls_err[k] !== bad || ls_rdata[k] !== exp_rd) begin
          errors++;
          $display("FAIL done_data inst%0d got err=%b rdata=%h want err=%b rdata=%h",
                   k, ls_err[k], ls_rdata[k], bad, exp_rd);
        end
      end
      if (poke && i == 2) begin
        ls_valid[k] = 1'b1; ls_is_store[k] = 1'b1; ls_addr[k] = 12'h004; ls_wdata[k] = 32'hBAD0BAD0;
      end
      if (i == 4) ls_valid[k] = 1'b0;
      @(negedge clk);
    end
    exp_done = bad ? 1 : (st ? 2 : 2 + lat);
    checks++;
    if (en_n != (bad ? 0 : 1) || (!bad && en_at != 1)) begin
      errors++;
      $display("FAIL enable_count inst%0d got n=%0d at T+%0d want n=%0d at T+1", k, en_n, en_at, bad ? 0 : 1);
    end
    checks++;
    if (done_n != 1 || done_at != exp_done) begin
      errors++;
      $display("FAIL done_cycle inst%0d got n=%0d at T+%0d want n=1 at T+%0d", k, done_n, done_at, exp_done);
    end
    if (!bad && st) ref_mem[k][a[11:2]] = wd;
    if (!bad && !st) rd_ref[k] = exp_rd;
    checks++;
    if (ls_rdata[k] !== rd_ref[k]) begin
      errors++;
      $display("FAIL rdata_hold inst%0d got %h want %h", k, ls_rdata[k], rd_ref[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ls_ready[k] !== 1'b0 || ls_done[k] !== 1'b0 || ls_err[k] !== 1'b0 || dm_enable[k] !== 1'b0 ||
          dm_write[k] !== 1'b0 || dm_addr[k] !== 10'h000 || dm_wdata[k] !== 32'h0 || ls_rdata[k] !== 32'h0) begin
        errors++;
        $display("FAIL reset_state inst%0d rdy=%b done=%b err=%b en=%b we=%b addr=%h wd=%h rd=%h want all 0",
                 k, ls_ready[k], ls_done[k], ls_err[k], dm_enable[k], dm_write[k], dm_addr[k], dm_wdata[k], ls_rdata[k]);
      end
      // Request presented together with reset must be dropped.
      ls_valid[k] = 1'b1; ls_is_store[k] = 1'b1; ls_addr[k] = 12'h010; ls_wdata[k] = 32'h12345678;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      ls_valid[k] = 1'b0; reset[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ls_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_reset inst%0d got %b want 1", k, ls_ready[k]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (dm_enable[k] !== 1'b0 || ls_done[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_drop inst%0d got en=%b done=%b want 0 0", k, dm_enable[k], ls_done[k]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store_load();
    do_req(0, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0);
    do_req(0, 1'b0, 12'h010, 32'h0, 1'b0);
    do_req(1, 1'b1, 12'h010, 32'hCAFEF00D, 1'b0);
    do_req(1, 1'b0, 12'h010, 32'h0, 1'b0);
  endtask

  task automatic test_misaligned();
    do_req(0, 1'b0, 12'h013, 32'h0, 1'b0);
    do_req(1, 1'b1, 12'h022, 32'h55AA55AA, 1'b0);
  endtask

  task automatic test_range();
    do_req(0, 1'b1, 12'h400, 32'hA5A5A5A5, 1'b0);
    do_req(0, 1'b1, 12'h3FC, 32'h0BADF00D, 1'b0);
    do_req(0, 1'b0, 12'h3FC, 32'h0, 1'b0);
    do_req(0, 1'b0, 12'hFFC, 32'h0, 1'b0);
    do_req(1, 1'b1, 12'hFFC, 32'h13579BDF, 1'b0);
    do_req(1, 1'b0, 12'hFFC, 32'h0, 1'b0);
  endtask

  task automatic test_wait_ignore();
    do_req(1, 1'b1, 12'h020, 32'h2468ACE0, 1'b0);
    do_req(1, 1'b0, 12'h020, 32'h0, 1'b1);
    do_req(1, 1'b0, 12'h004, 32'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int k;
    k = 1;
    do_req(k, 1'b1, 12'h030, 32'h77778888, 1'b0);
    ls_valid[k] = 1'b1; ls_is_store[k] = 1'b0; ls_addr[k] = 12'h030;
    @(negedge clk);
    ls_valid[k] = 1'b0;
    checks++;
    if (dm_enable[k] !== 1'b1) begin
      errors++;
      $display("FAIL mid_enable inst%0d got %b want 1", k, dm_enable[k]);
    end
    @(negedge clk);
    reset[k] = 1'b1;
    #1;
    checks++;
    if (ls_ready[k] !== 1'b0) begin
      errors++;
      $display("FAIL mid_ready_in_reset inst%0d got %b want 0", k, ls_ready[k]);
    end
    @(negedge clk);
    reset[k] = 1'b0;
    #1;
    checks++;
    if (ls_ready[k] !== 1'b1 || ls_done[k] !== 1'b0 || ls_err[k] !== 1'b0 || dm_enable[k] !== 1'b0 ||
        dm_write[k] !== 1'b0 || dm_addr[k] !== 10'h000 || dm_wdata[k] !== 32'h0 || ls_rdata[k] !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_state inst%0d rdy=%b done=%b en=%b addr=%h wd=%h rd=%h want 1 0 0 0 0 0",
               k, ls_ready[k], ls_done[k], dm_enable[k], dm_addr[k], dm_wdata[k], ls_rdata[k]);
    end
    rd_ref[k] = 32'h0;
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (ls_done[k] !== 1'b0 || dm_enable[k] !== 1'b0) begin
        errors++;
        $display("FAIL mid_abort inst%0d got done=%b en=%b want 0 0", k, ls_done[k], dm_enable[k]);
      end
      @(negedge clk);
    end
    do_req(k, 1'b1, 12'h034, 32'h9999AAAA, 1'b0);
    do_req(k, 1'b0, 12'h034, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back(input int k);
    bit          sts    [4];
    logic [31:0] wds    [4];
    logic [31:0] exp_rd [4];
    int          exp_done [4];
    int n, j, nd, last_done, lat;
    bit pend;
    lat = lat_of(k);
    for (int q = 0; q < 4; q++) begin
      sts[q] = (q % 2 == 0);
      wds[q] = $urandom;
    end
    while (ls_ready[k] !== 1'b1) @(negedge clk);
    j = 0; nd = 0; n = 0; pend = 0; last_done = -1;
    ls_valid[k] = 1'b1; ls_is_store[k] = sts[0]; ls_addr[k] = 12'h000; ls_wdata[k] = wds[0];
    while (nd < 4 && n < 80) begin
      if (pend) begin
        pend = 0;
        j++;
        if (j < 4) begin
          ls_is_store[k] = sts[j]; ls_addr[k] = 12'(j * 4); ls_wdata[k] = wds[j];
        end else begin
          ls_valid[k] = 1'b0;
        end
      end
      if (ls_done[k] === 1'b1) begin
        checks++;
        if (n != exp_done[nd] || ls_err[k] !== 1'b0 || (!sts[nd] && ls_rdata[k] !== exp_rd[nd])) begin
          errors++;
          $display("FAIL b2b_done inst%0d req%0d got cyc=%0d err=%b rd=%h want cyc=%0d err=0 rd=%h",
                   k, nd, n, ls_err[k], ls_rdata[k], exp_done[nd], exp_rd[nd]);
        end
        last_done = n;
        nd++;
      end
      if (j < 4 && ls_ready[k] === 1'b1) begin
        pend = 1;
        checks++;
        if (j > 0 && n != last_done + 1) begin
          errors++;
          $display("FAIL b2b_accept inst%0d req%0d got cyc=%0d want cyc=%0d", k, j, n, last_done + 1);
        end
        if (sts[j]) begin
          ref_mem[k][j] = wds[j];
          exp_done[j] = n + 2;
        end else begin
          exp_rd[j] = ref_mem[k][j];
          rd_ref[k] = exp_rd[j];
          exp_done[j] = n + 2 + lat;
        end
      end
      @(negedge clk);
      n++;
    end
    ls_valid[k] = 1'b0;
    checks++;
    if (nd != 4) begin
      errors++;
      $display("FAIL b2b_count inst%0d got %0d done pulses want 4", k, nd);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (ls_done[k] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_extra_done inst%0d got 1 want 0", k);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 25; r++) begin
        case ($urandom_range(0, 3))
          0:       a = 12'($urandom);
          1:       a = 12'($urandom_range(1020, 1030));
          default: a = 12'($urandom_range(0, 15)) << 2;
        endcase
        do_req(k, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mclr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1; ls_valid[k] = 1'b0; ls_is_store[k] = 1'b0;
      ls_addr[k] = 12'h000; ls_wdata[k] = 32'h0; rd_ref[k] = 32'h0;
      for (int w = 0; w < 1024; w++) ref_mem[k][w] = 32'h0;
    end
    repeat (3) @(negedge clk);
    mclr = 1'b0;
    test_reset();
    test_store_load();
    test_misaligned();
    test_range();
    test_wait_ignore();
    test_reset_mid();
    test_back_to_back(0);
    test_back_to_back(1);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
